// File: rtl/apb_pkg.sv
// apb_pkg: shared types and address-map constants for the APB bridge and decoder
package apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
  localparam int NUM_SLAVES = 4;
  localparam int SLV_IDX_LSB = 12;
  localparam int SLV_IDX_MSB = 13;
  localparam int REGION_LSB = 14;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1000_0000;
endpackage

// File: rtl/apb_addr_decode.sv
// apb_addr_decode: region hit and one-hot slave select from a request address
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic [31:SLV_IDX_LSB]  req_addr,
  output logic                   in_region,
  output logic [NUM_SLAVES-1:0]  sel
);
  assign in_region = req_addr[31:REGION_LSB] == BASE_ADDR[31:REGION_LSB];
  assign sel = in_region ? NUM_SLAVES'(1) << req_addr[SLV_IDX_MSB:SLV_IDX_LSB] : '0;
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready request to APB SETUP/ACCESS master with decode error and timeout
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic                  req_write,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [31:0]           PADDR,
  output logic [31:0]           PWDATA,
  output logic                  PWRITE,
  output logic [NUM_SLAVES-1:0] PSEL,
  output logic                  PENABLE,
  input  logic [31:0]           PRDATA0,
  input  logic [31:0]           PRDATA1,
  input  logic [31:0]           PRDATA2,
  input  logic [31:0]           PRDATA3,
  input  logic [NUM_SLAVES-1:0] PREADY
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  apb_state_e state, state_d;
  logic [31:0] paddr_d, pwdata_d, rsp_rdata_d, prdata_mux;
  logic pwrite_d, penable_d, rsp_valid_d, rsp_err_d, in_region, pready_mux;
  logic [NUM_SLAVES-1:0] psel_d, dec_sel;
  logic [1:0] sel, sel_d;
  logic [CW-1:0] cnt, cnt_d;
  apb_addr_decode #(.BASE_ADDR(BASE_ADDR)) u_dec (
    .req_addr (req_addr[31:SLV_IDX_LSB]),
    .in_region(in_region),
    .sel      (dec_sel)
  );
  assign req_ready = state == IDLE;
  assign prdata_mux = sel == 2'd0 ? PRDATA0 : sel == 2'd1 ? PRDATA1 : sel == 2'd2 ? PRDATA2 : PRDATA3;
  assign pready_mux = PREADY[sel];
  always_comb begin
    state_d = state;
    paddr_d = PADDR;
    pwdata_d = PWDATA;
    pwrite_d = PWRITE;
    psel_d = PSEL;
    penable_d = PENABLE;
    sel_d = sel;
    cnt_d = cnt;
    rsp_valid_d = 1'b0;
    rsp_err_d = 1'b0;
    rsp_rdata_d = '0;
    case (state)
      IDLE: if (req_valid) begin
        if (in_region) begin
          state_d = SETUP;
          paddr_d = req_addr;
          pwrite_d = req_write;
          pwdata_d = req_write ? req_wdata : '0;
          psel_d = dec_sel;
          sel_d = req_addr[SLV_IDX_MSB:SLV_IDX_LSB];
        end else begin
          rsp_valid_d = 1'b1;
          rsp_err_d = 1'b1;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        penable_d = 1'b1;
        cnt_d = '0;
      end
      ACCESS: if (pready_mux || cnt == CW'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        psel_d = '0;
        penable_d = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d = !pready_mux;
        rsp_rdata_d = (pready_mux && !PWRITE) ? prdata_mux : '0;
      end else begin
        cnt_d = cnt + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
      PADDR <= '0;
      PWDATA <= '0;
      PWRITE <= 1'b0;
      PSEL <= '0;
      PENABLE <= 1'b0;
      sel <= '0;
      cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state <= state_d;
      PADDR <= paddr_d;
      PWDATA <= pwdata_d;
      PWRITE <= pwrite_d;
      PSEL <= psel_d;
      PENABLE <= penable_d;
      sel <= sel_d;
      cnt <= cnt_d;
      rsp_valid <= rsp_valid_d;
      rsp_err <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed checks of the APB master bridge against registered-PREADY slave models
module tb_apb_master_bridge;
  logic PCLK = 1'b0, PRESET = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err, PWRITE, PENABLE;
  logic [31:0] rsp_rdata, PADDR, PWDATA, PRDATA0, PRDATA1, PRDATA2, PRDATA3;
  logic [3:0] PSEL, PREADY, pr_q = '0;
  logic hang = 1'b0, force0 = 1'b0;
  logic [31:0] mem [4][16];
  int errors = 0, checks = 0;
  int n;
  logic seen;
  always #5 PCLK = ~PCLK;
  apb_master_bridge dut (
    .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA0(PRDATA0), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PRDATA3(PRDATA3),
    .PREADY(PREADY)
  );
  assign PRDATA0 = mem[0][PADDR[5:2]];
  assign PRDATA1 = mem[1][PADDR[5:2]];
  assign PRDATA2 = mem[2][PADDR[5:2]];
  assign PRDATA3 = mem[3][PADDR[5:2]];
  always_comb begin
    PREADY = pr_q;
    if (hang) PREADY[2] = 1'b0;
    if (force0) PREADY[0] = 1'b1;
  end
  // Slaves register PREADY, so every transfer sees two ACCESS cycles
  always @(posedge PCLK) begin
    for (int i = 0; i < 4; i++) begin
      pr_q[i] <= PRESET ? 1'b0 : PSEL[i] & PENABLE & ~pr_q[i];
      if (PRESET) for (int j = 0; j < 16; j++) mem[i][j] <= '0;
      else if (PSEL[i] && PENABLE && PREADY[i] && PWRITE) mem[i][PADDR[5:2]] <= PWDATA;
    end
    if (PRESET) begin
      mem[2][0] <= 32'hDEAD_BEEF;
      mem[3][3] <= 32'hCAFE_0003;
    end
  end
  task automatic tick();
    @(posedge PCLK);
    @(negedge PCLK);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic w);
    req_valid = 1'b1;
    req_addr = a;
    req_wdata = d;
    req_write = w;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_psel", PSEL, 4'b0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, PWRITE}, 0);
    chk("rst_ready", req_ready, 1);
    PRESET = 1'b0;
    tick();
    // write slave 1
    req(32'h1000_1004, 32'h0000_00A5, 1'b1);
    chk("w_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("w_setup_psel", PSEL, 4'b0010);
    chk("w_setup_pen", PENABLE, 0);
    chk("w_pwrite", PWRITE, 1);
    chk("w_pwdata", PWDATA, 32'hA5);
    chk("w_paddr", PADDR, 32'h1000_1004);
    chk("w_busy", req_ready, 0);
    tick();
    chk("w_acc1", {PSEL, PENABLE}, {4'b0010, 1'b1});
    chk("w_acc1_rsp", rsp_valid, 0);
    tick();
    chk("w_acc2", {PSEL, PENABLE}, {4'b0010, 1'b1});
    tick();
    chk("w_rsp", {rsp_valid, rsp_err}, 2'b10);
    chk("w_rdata", rsp_rdata, 0);
    chk("w_release", {PSEL, PENABLE}, 5'b0);
    chk("w_mem", mem[1][1], 32'hA5);
    tick();
    chk("w_pulse", rsp_valid, 0);
    // read back
    req(32'h1000_1004, 32'h1111_1111, 1'b0);
    tick();
    req_valid = 1'b0;
    chk("r_psel", PSEL, 4'b0010);
    chk("r_pwrite", PWRITE, 0);
    chk("r_pwdata", PWDATA, 0);
    tick();
    tick();
    tick();
    chk("r_rsp", {rsp_valid, rsp_err}, 2'b10);
    chk("r_rdata", rsp_rdata, 32'hA5);
    tick();
    // hung slave 2 with slave 0 ready asserted
    hang = 1'b1;
    force0 = 1'b1;
    req(32'h1000_2000, 32'h0, 1'b0);
    tick();
    req_valid = 1'b0;
    chk("h_psel", PSEL, 4'b0100);
    tick();
    n = 0;
    while (PENABLE === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("h_cycles", n, 16);
    chk("h_rsp", {rsp_valid, rsp_err}, 2'b11);
    chk("h_rdata", rsp_rdata, 0);
    chk("h_psel_rel", PSEL, 4'b0);
    chk("h_ready", req_ready, 1);
    hang = 1'b0;
    force0 = 1'b0;
    tick();
    // unmapped
    req(32'h2000_0000, 32'h0, 1'b0);
    tick();
    req_valid = 1'b0;
    chk("u_rsp", {rsp_valid, rsp_err}, 2'b11);
    chk("u_rdata", rsp_rdata, 0);
    chk("u_psel", PSEL, 4'b0);
    chk("u_ready", req_ready, 1);
    tick();
    chk("u_pulse", rsp_valid, 0);
    // reset during ACCESS
    req(32'h1000_3008, 32'h0000_1234, 1'b1);
    tick();
    req_valid = 1'b0;
    tick();
    chk("x_access", {PSEL, PENABLE}, {4'b1000, 1'b1});
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    chk("x_release", {PSEL, PENABLE}, 5'b0);
    chk("x_ready", req_ready, 1);
    seen = rsp_valid;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen |= rsp_valid;
    end
    chk("x_no_rsp", seen, 0);
    chk("x_no_write", mem[3][2], 0);
    // back-to-back: write slave 0 then read slave 3
    req(32'h1000_0000, 32'h0000_0077, 1'b1);
    tick();
    req(32'h1000_300C, 32'h0, 1'b0);
    chk("b_psel0", PSEL, 4'b0001);
    chk("b_hold", req_ready, 0);
    tick();
    tick();
    chk("b_acc2", {PSEL, PENABLE}, {4'b0001, 1'b1});
    tick();
    chk("b_rsp1", {rsp_valid, rsp_err}, 2'b10);
    chk("b_accept2", req_ready, 1);
    chk("b_idle_bus", {PSEL, PENABLE}, 5'b0);
    tick();
    req_valid = 1'b0;
    chk("b_psel3", {PSEL, PENABLE}, {4'b1000, 1'b0});
    chk("b_rsp_gone", rsp_valid, 0);
    chk("b_mem0", mem[0][0], 32'h77);
    tick();
    tick();
    tick();
    chk("b_rsp2", {rsp_valid, rsp_err}, 2'b10);
    chk("b_rdata2", rsp_rdata, 32'hCAFE_0003);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB initiator that drives the peripheral bus.
- Converts a simple valid/ready request from the core side into APB SETUP/ACCESS phases toward up to four slaves, such as the UART/FIFO peripherals.
- Decodes the slave select from the address, waits for PREADY, and returns read data and an error flag as a one-cycle response pulse.
- Handles unmapped addresses and hung slaves (timeout) without a bus lockup.

Parameters:
- BASE_ADDR, 32'h1000_0000: peripheral region base; req_addr[31:14] must equal BASE_ADDR[31:14].
- TIMEOUT_CYCLES, 16: maximum number of ACCESS cycles without PREADY before the transfer is aborted with an error.

Ports:
- PCLK  in  1  clock
- PRESET  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high together with req_valid
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- req_write  in  1  1=write, 0=read
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_err  out  1  decode error or timeout
- PADDR  out  32  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PSEL  out  4  one-hot slave select
- PENABLE  out  1  APB access phase
- PRDATA0..PRDATA3  in  32 each  per-slave read data
- PREADY  in  4  per-slave ready

Behaviour:
- Interface: one clock, PCLK. PRESET is synchronous and active-high.
- Reset: while PRESET is high at a PCLK edge, every output goes to 0 and the state goes to IDLE. This includes PSEL, PENABLE, PADDR, PWDATA, PWRITE, rsp_valid, rsp_rdata, rsp_err and the timeout counter. req_ready is 1 after reset because the state is IDLE.
- States: IDLE, SETUP, ACCESS.
- req_ready = (state==IDLE). It is combinational from state only.
- IDLE, request accepted, address in region:
  - Latch PADDR=req_addr and PWRITE=req_write.
  - PWDATA=req_wdata for writes, 0 for reads.
  - PSEL bit req_addr[13:12] is set.
  - Next state is SETUP.
- IDLE, request accepted, address outside region:
  - No PSEL is driven.
  - Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0. State stays IDLE.
- SETUP: PSEL held, PENABLE=0. Lasts exactly one cycle, then ACCESS; PENABLE goes to 1 on entry.
- ACCESS:
  - All bus outputs are held stable.
  - At each edge, only PREADY[sel] is sampled. PREADY bits of non-selected slaves are ignored.
  - When PREADY[sel]=1: PSEL and PENABLE go to 0, rsp_rdata=PRDATA[sel] for reads (0 for writes), rsp_err=0, rsp_valid=1, next state is IDLE.
  - Timeout counter clears on entering ACCESS and increments each ACCESS cycle without ready.
  - On the edge where the counter equals TIMEOUT_CYCLES-1 with no ready: PSEL and PENABLE go to 0, rsp_valid=1, rsp_err=1, rsp_rdata=0, next state is IDLE.
- Latency: accept at edge T; SETUP is the cycle after T; ACCESS starts the cycle after SETUP. With a zero-wait slave, rsp_valid appears 3 cycles after acceptance.
- The codebase peripherals register PREADY, so they present a 2-cycle ACCESS, giving a 4-cycle transfer.
- rsp_valid lasts exactly one cycle and has no backpressure. It coincides with IDLE, so a new request can be accepted in the same cycle. There is always at least one cycle between ACCESS and the next SETUP.
- Reset mid-transfer (SETUP or ACCESS): the bus is released at that edge and no response is ever emitted for the aborted request.
- Requests arriving while not IDLE are not accepted. The requester holds req_* stable until req_ready is high.

Decomposition:
- Package apb_pkg holds:
  - apb_state_e enum (IDLE/SETUP/ACCESS)
  - NUM_SLAVES=4
  - SLV_IDX_LSB=12, SLV_IDX_MSB=13, REGION_LSB=14
  - the BASE_ADDR default
- Sub-module apb_addr_decode (combinational): inputs req_addr; outputs in_region and a one-hot 4-bit select. It is reused for a future interconnect.
- The PRDATA/PREADY muxing stays in the top level, indexed by the registered select index.

Test Plan:
- Write slave 1: req_addr=32'h1000_1004, wdata=32'h0000_00A5, slave model with registered PREADY. Expect PSEL=4'b0010 for 1 SETUP cycle plus 2 ACCESS cycles, PWRITE=1, PWDATA=0xA5, rsp_valid one cycle with rsp_err=0. The slave register at offset 0x4 reads 0xA5.
- Read back 32'h1000_1004. Expect PWRITE=0, PWDATA=0, rsp_rdata=32'h0000_00A5, rsp_err=0.
- Hung slave: PREADY[2]=0, read 32'h1000_2000. Expect exactly 16 cycles with PENABLE=1, then rsp_valid=1, rsp_err=1, rsp_rdata=0, PSEL=0. Hold PREADY[0]=1 throughout and confirm it is ignored.
- Unmapped: req_addr=32'h2000_0000. Expect PSEL stays 0, and in the cycle after acceptance rsp_valid=1, rsp_err=1.
- Reset during ACCESS: PRESET=1 for one cycle. Expect PSEL=0, PENABLE=0 after that edge and no rsp_valid; req_ready=1 afterward.
- Back-to-back: req_valid held with a write to slave 0 then a read from slave 3. Expect the second request accepted in the cycle rsp_valid pulses for the first, one idle cycle on the bus between transfers, and PSEL sequence 0001 then 1000.
